// File: rtl/lcd_pkg.sv
// Shared constants and FSM encoding for the LCD BCD scheduler.
// digit_char maps a BCD digit to its ASCII code, or to a space when blanked.
package lcd_pkg;

    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_SPACE = 8'h20;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CONV   = 3'd1,
        ST_SEND_H = 3'd2,
        ST_SEND_T = 3'd3,
        ST_SEND_O = 3'd4
    } state_t;

    function automatic logic [7:0] digit_char(input logic [3:0] digit, input logic blank);
        return blank ? ASCII_SPACE : (ASCII_ZERO + {4'd0, digit});
    endfunction

endpackage

// File: rtl/binary_to_BCD.sv
// Combinational 8-bit binary to three-digit BCD converter (shift-and-add-3).
// Hundreds needs only two bits because the input never exceeds 255.
module binary_to_BCD (
    input  logic [7:0] bin,
    output logic [1:0] hundreds,
    output logic [3:0] tens,
    output logic [3:0] ones
);

    logic [9:0] bcd;

    always_comb begin
        bcd = 10'd0;
        for (int i = 7; i >= 0; i--) begin
            if (bcd[3:0] >= 4'd5) bcd[3:0] = bcd[3:0] + 4'd3;
            if (bcd[7:4] >= 4'd5) bcd[7:4] = bcd[7:4] + 4'd3;
            bcd = {bcd[8:0], bin[i]};
        end
    end

    assign hundreds = bcd[9:8];
    assign tens     = bcd[7:4];
    assign ones     = bcd[3:0];

endmodule

// File: rtl/lcd_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or above rr_ptr,
// wrapping modulo NREQ. Produces a one-hot grant, its index and an any flag.
module lcd_rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   rr_ptr,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   grant_idx,
    output logic            any
);

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!any && req[(int'(rr_ptr) + k) % NREQ]) begin
                any                                   = 1'b1;
                grant[(int'(rr_ptr) + k) % NREQ]      = 1'b1;
                grant_idx                             = IW'((int'(rr_ptr) + k) % NREQ);
            end
        end
    end

endmodule

// File: rtl/lcd_bcd_scheduler.sv
// Shares one BCD converter among NREQ requesters: round-robin grant, convert the
// latched value, then emit hundreds/tens/ones ASCII characters to the LCD port.
module lcd_bcd_scheduler
    import lcd_pkg::*;
#(
    parameter int NREQ       = 4,
    parameter int ADDR_W     = 5,
    parameter int BLANK_LEAD = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*8-1:0]      req_value,
    input  logic [NREQ*ADDR_W-1:0] req_addr,
    output logic [NREQ-1:0]        ack,
    output logic                   busy,
    output logic                   chr_valid,
    input  logic                   chr_ready,
    output logic [ADDR_W-1:0]      chr_addr,
    output logic [7:0]             chr_data
);

    localparam int IW = $clog2(NREQ);

    state_t              state, state_nx;
    logic [IW-1:0]       rr_ptr, gidx_q, grant_idx;
    logic [NREQ-1:0]     grant;
    logic                any_req;
    logic [7:0]          value_q;
    logic [ADDR_W-1:0]   base_q;
    logic [1:0]          hund_q, conv_h;
    logic [3:0]          tens_q, ones_q, conv_t, conv_o;
    logic                handshake, blank_h, blank_t;

    lcd_rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
        .req       (req),
        .rr_ptr    (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any       (any_req)
    );

    binary_to_BCD u_bcd (
        .bin      (value_q),
        .hundreds (conv_h),
        .tens     (conv_t),
        .ones     (conv_o)
    );

    // A character transfers on a rising edge where chr_valid && chr_ready; once
    // chr_valid rises, chr_addr/chr_data hold until that transfer happens.
    assign handshake = chr_valid && chr_ready;
    assign busy      = (state != ST_IDLE);
    assign blank_h   = (BLANK_LEAD != 0) && (hund_q == 2'd0);
    assign blank_t   = blank_h && (tens_q == 4'd0);

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:   if (any_req)   state_nx = ST_CONV;
            ST_CONV:                  state_nx = ST_SEND_H;
            ST_SEND_H: if (handshake) state_nx = ST_SEND_T;
            ST_SEND_T: if (handshake) state_nx = ST_SEND_O;
            ST_SEND_O: if (handshake) state_nx = ST_IDLE;
            default:                  state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        chr_valid = 1'b0;
        chr_addr  = '0;
        chr_data  = 8'h00;
        case (state)
            ST_SEND_H: begin
                chr_valid = 1'b1;
                chr_addr  = base_q;
                chr_data  = digit_char({2'b00, hund_q}, blank_h);
            end
            ST_SEND_T: begin
                chr_valid = 1'b1;
                chr_addr  = base_q + ADDR_W'(1);
                chr_data  = digit_char(tens_q, blank_t);
            end
            ST_SEND_O: begin
                chr_valid = 1'b1;
                chr_addr  = base_q + ADDR_W'(2);
                chr_data  = digit_char(ones_q, 1'b0);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            rr_ptr  <= '0;
            gidx_q  <= '0;
            value_q <= 8'd0;
            base_q  <= '0;
            hund_q  <= 2'd0;
            tens_q  <= 4'd0;
            ones_q  <= 4'd0;
            ack     <= '0;
        end else begin
            state <= state_nx;
            ack   <= '0;
            if (state == ST_IDLE && any_req) begin
                value_q <= req_value[grant_idx*8 +: 8];
                base_q  <= req_addr[grant_idx*ADDR_W +: ADDR_W];
                gidx_q  <= grant_idx;
                ack     <= grant;
            end
            if (state == ST_CONV) begin
                hund_q <= conv_h;
                tens_q <= conv_t;
                ones_q <= conv_o;
            end
            // Pointer moves past the served requester only once its last digit is out.
            if (state == ST_SEND_O && handshake)
                rr_ptr <= (gidx_q == IW'(NREQ - 1)) ? '0 : gidx_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_lcd_bcd_scheduler.sv
// Bench for lcd_bcd_scheduler: two instances (leading blanks on/off) share stimulus;
// expectations come from decimal arithmetic and a round-robin list model.
module tb_lcd_bcd_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] req_value;
    logic [19:0] req_addr;
    logic        chr_ready;
    logic [3:0]  ack1, ack0;
    logic        busy1, busy0, v1, v0;
    logic [4:0]  a1, a0;
    logic [7:0]  d1, d0;

    int n_vec  = 0;
    int n_err  = 0;
    int exp_ptr = 0;

    always #5 clk = ~clk;

    lcd_bcd_scheduler #(.NREQ(4), .ADDR_W(5), .BLANK_LEAD(1)) u_dut (
        .clk(clk), .rst(rst), .req(req), .req_value(req_value), .req_addr(req_addr),
        .ack(ack1), .busy(busy1), .chr_valid(v1), .chr_ready(chr_ready),
        .chr_addr(a1), .chr_data(d1)
    );

    lcd_bcd_scheduler #(.NREQ(4), .ADDR_W(5), .BLANK_LEAD(0)) u_dut_nb (
        .clk(clk), .rst(rst), .req(req), .req_value(req_value), .req_addr(req_addr),
        .ack(ack0), .busy(busy0), .chr_valid(v0), .chr_ready(chr_ready),
        .chr_addr(a0), .chr_data(d0)
    );

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [23:0] ref_text(input int v, input bit blank_lead);
        int h, t, o;
        h = v / 100;
        t = (v / 10) % 10;
        o = v % 10;
        ref_text[23:16] = (blank_lead && h == 0) ? 8'h20 : 8'(8'h30 + h);
        ref_text[15:8]  = (blank_lead && h == 0 && t == 0) ? 8'h20 : 8'(8'h30 + t);
        ref_text[7:0]   = 8'(8'h30 + o);
    endfunction

    function automatic logic [14:0] ref_addrs(input int a);
        for (int i = 0; i < 3; i++) ref_addrs[5*i +: 5] = 5'((a + i) % 32);
    endfunction

    function automatic int ref_grant(input logic [3:0] mask, input int ptr);
        for (int k = 0; k < 4; k++)
            if (mask[(ptr + k) % 4]) return (ptr + k) % 4;
        return -1;
    endfunction

    // ---------------- drivers ----------------
    task automatic set_req(input int i, input int v, input int a);
        req_value[8*i +: 8] = 8'(v);
        req_addr[5*i +: 5]  = 5'(a);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        req = 4'b0000;
        @(negedge clk);
        rst = 1'b0;
        exp_ptr = 0;
    endtask

    // Raises req=mask at a negedge while idle, drops it once ack is seen, collects
    // the three transferred characters; optionally holds ready low 3 cycles on the tens digit.
    task automatic do_txn(input logic [3:0] mask, input bit stall,
                          output logic [3:0] ack_vec, output int ack_lat,
                          output logic [14:0] addrs, output logic [23:0] datas,
                          output logic [23:0] datas_nb, output bit one_cycle_ack,
                          output bit stall_stable, output int busy_cycles,
                          output bit idle_after, output bit timeout);
        int n;
        bit do_stall;
        logic [4:0] ha;
        logic [7:0] hd;
        do_stall = stall;
        ack_vec = '0; ack_lat = 0; addrs = '0; datas = '0; datas_nb = '0;
        one_cycle_ack = 1'b1; stall_stable = 1'b1; busy_cycles = 0;
        idle_after = 1'b0; timeout = 1'b0;
        req = mask;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (ack1 != 4'b0000) begin
                ack_vec = ack1;
                ack_lat = k;
                break;
            end
        end
        req = 4'b0000;
        if (ack_vec == 4'b0000) begin
            timeout = 1'b1;
            return;
        end
        if (busy1) busy_cycles++;
        n = 0;
        for (int c = 0; c < 40 && n < 3; c++) begin
            @(negedge clk);
            if (ack1 != 4'b0000) one_cycle_ack = 1'b0;
            if (busy1) busy_cycles++;
            if (do_stall && n == 1 && v1) begin
                do_stall = 1'b0;
                chr_ready = 1'b0;
                ha = a1;
                hd = d1;
                repeat (3) begin
                    @(negedge clk);
                    if (busy1) busy_cycles++;
                    if (!v1 || a1 !== ha || d1 !== hd) stall_stable = 1'b0;
                end
                chr_ready = 1'b1;
            end
            if (v1 && chr_ready) begin
                addrs[5*n +: 5]     = a1;
                datas[23-8*n -: 8]  = d1;
                datas_nb[23-8*n -: 8] = d0;
                n++;
            end
        end
        if (n < 3) timeout = 1'b1;
        @(negedge clk);
        idle_after = !busy1 && !v1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        @(negedge clk);
        n_vec++; if (ack1 !== 4'b0000) begin n_err++; $display("FAIL reset_ack got=%b exp=0000", ack1); end
        n_vec++; if (busy1 !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy1); end
        n_vec++; if (v1 !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b exp=0", v1); end
        n_vec++; if (a1 !== 5'd0) begin n_err++; $display("FAIL reset_addr got=%0d exp=0", a1); end
        n_vec++; if (d1 !== 8'h00) begin n_err++; $display("FAIL reset_data got=%h exp=00", d1); end
        rst = 1'b0;
        exp_ptr = 0;
        @(negedge clk);
        n_vec++; if (busy1 !== 1'b0) begin n_err++; $display("FAIL reset_idle_busy got=%b exp=0", busy1); end
    endtask

    task automatic test_single();
        logic [3:0] av; int lat, bc; logic [14:0] ad; logic [23:0] dd, dn; bit oc, ss, ia, to;
        set_req(0, 255, 0);
        do_txn(4'b0001, 1'b0, av, lat, ad, dd, dn, oc, ss, bc, ia, to);
        exp_ptr = 1;
        n_vec++; if (to) begin n_err++; $display("FAIL single_timeout got=1 exp=0"); end
        n_vec++; if (av !== 4'b0001) begin n_err++; $display("FAIL single_ack got=%b exp=0001", av); end
        n_vec++; if (lat != 1) begin n_err++; $display("FAIL single_ack_latency got=%0d exp=1", lat); end
        n_vec++; if (oc !== 1'b1) begin n_err++; $display("FAIL single_ack_width got=multi exp=1cycle"); end
        n_vec++; if (ad !== ref_addrs(0)) begin n_err++; $display("FAIL single_addr got=%h exp=%h", ad, ref_addrs(0)); end
        n_vec++; if (dd !== ref_text(255, 1)) begin n_err++; $display("FAIL single_data got=%h exp=%h", dd, ref_text(255, 1)); end
        n_vec++; if (bc != 4) begin n_err++; $display("FAIL single_busy_cycles got=%0d exp=4", bc); end
        n_vec++; if (ia !== 1'b1) begin n_err++; $display("FAIL single_idle_after got=%b exp=1", ia); end
    endtask

    task automatic test_blanking();
        int vals[7];
        logic [3:0] av; int lat, bc; logic [14:0] ad; logic [23:0] dd, dn; bit oc, ss, ia, to;
        vals = '{7, 0, 100, 10, 9, 99, 200};
        foreach (vals[j]) begin
            int i, a, g;
            i = $urandom_range(0, 3);
            a = $urandom_range(0, 31);
            set_req(i, vals[j], a);
            g = ref_grant(4'(1 << i), exp_ptr);
            do_txn(4'(1 << i), 1'b0, av, lat, ad, dd, dn, oc, ss, bc, ia, to);
            exp_ptr = (g + 1) % 4;
            n_vec++; if (to || av !== 4'(1 << g)) begin n_err++; $display("FAIL blank_ack v=%0d got=%b exp=%b", vals[j], av, 4'(1 << g)); end
            n_vec++; if (dd !== ref_text(vals[j], 1)) begin n_err++; $display("FAIL blank_on v=%0d got=%h exp=%h", vals[j], dd, ref_text(vals[j], 1)); end
            n_vec++; if (dn !== ref_text(vals[j], 0)) begin n_err++; $display("FAIL blank_off v=%0d got=%h exp=%h", vals[j], dn, ref_text(vals[j], 0)); end
            n_vec++; if (ad !== ref_addrs(a)) begin n_err++; $display("FAIL blank_addr a=%0d got=%h exp=%h", a, ad, ref_addrs(a)); end
        end
    endtask

    task automatic test_round_robin();
        logic [12:0] exp_q[$];
        logic [12:0] got_q[$];
        int grants[$];
        logic [3:0] prev_ack;
        int g;
        pulse_reset();
        for (int i = 0; i < 4; i++) set_req(i, $urandom_range(0, 255), $urandom_range(0, 31));
        req = 4'b1111;
        prev_ack = 4'b0000;
        for (int c = 0; c < 80 && got_q.size() < 15; c++) begin
            @(negedge clk);
            if (ack1 != 4'b0000) begin
                n_vec++;
                if ($countones(ack1) != 1 || prev_ack != 4'b0000) begin
                    n_err++; $display("FAIL rr_ack_pulse got=%b prev=%b exp=onehot_single", ack1, prev_ack);
                end
                for (int i = 0; i < 4; i++) if (ack1[i]) grants.push_back(i);
                if (grants.size() >= 5) req = 4'b0000;
            end
            prev_ack = ack1;
            if (v1 && chr_ready) got_q.push_back({a1, d1});
        end
        req = 4'b0000;
        for (int j = 0; j < 5; j++) begin
            logic [23:0] t;
            logic [14:0] ad;
            g = ref_grant(4'b1111, exp_ptr);
            exp_ptr = (g + 1) % 4;
            t  = ref_text(int'(req_value[8*g +: 8]), 1);
            ad = ref_addrs(int'(req_addr[5*g +: 5]));
            for (int n = 0; n < 3; n++) exp_q.push_back({ad[5*n +: 5], t[23-8*n -: 8]});
            n_vec++;
            if (j >= grants.size() || grants[j] != g) begin
                n_err++; $display("FAIL rr_order idx=%0d got=%0d exp=%0d", j, (j < grants.size()) ? grants[j] : -1, g);
            end
        end
        n_vec++; if (got_q.size() != 15) begin n_err++; $display("FAIL rr_char_count got=%0d exp=15", got_q.size()); end
        for (int n = 0; n < 15 && n < got_q.size(); n++) begin
            n_vec++; if (got_q[n] !== exp_q[n]) begin n_err++; $display("FAIL rr_char idx=%0d got=%h exp=%h", n, got_q[n], exp_q[n]); end
        end
        for (int c = 0; c < 10 && busy1; c++) @(negedge clk);
    endtask

    task automatic test_backpressure();
        logic [3:0] av; int lat, bc, v, a, g; logic [14:0] ad; logic [23:0] dd, dn; bit oc, ss, ia, to;
        v = $urandom_range(100, 255);
        a = $urandom_range(0, 31);
        set_req(1, v, a);
        g = ref_grant(4'b0010, exp_ptr);
        do_txn(4'b0010, 1'b1, av, lat, ad, dd, dn, oc, ss, bc, ia, to);
        exp_ptr = (g + 1) % 4;
        n_vec++; if (to || av !== 4'b0010) begin n_err++; $display("FAIL bp_ack got=%b exp=0010", av); end
        n_vec++; if (ss !== 1'b1) begin n_err++; $display("FAIL bp_stable got=unstable exp=held"); end
        n_vec++; if (dd !== ref_text(v, 1)) begin n_err++; $display("FAIL bp_data got=%h exp=%h", dd, ref_text(v, 1)); end
        n_vec++; if (ad !== ref_addrs(a)) begin n_err++; $display("FAIL bp_addr got=%h exp=%h", ad, ref_addrs(a)); end
        n_vec++; if (bc != 7) begin n_err++; $display("FAIL bp_busy_cycles got=%0d exp=7", bc); end
    endtask

    task automatic test_addr_wrap();
        logic [3:0] av; int lat, bc, g; logic [14:0] ad; logic [23:0] dd, dn; bit oc, ss, ia, to;
        set_req(3, 123, 30);
        g = ref_grant(4'b1000, exp_ptr);
        do_txn(4'b1000, 1'b0, av, lat, ad, dd, dn, oc, ss, bc, ia, to);
        exp_ptr = (g + 1) % 4;
        n_vec++; if (to || ad !== {5'd0, 5'd31, 5'd30}) begin n_err++; $display("FAIL wrap_addr got=%h exp=%h", ad, {5'd0, 5'd31, 5'd30}); end
        n_vec++; if (dd !== 24'h313233) begin n_err++; $display("FAIL wrap_data got=%h exp=313233", dd); end
    endtask

    task automatic test_async_reset();
        logic [3:0] av; int lat, bc; logic [14:0] ad; logic [23:0] dd, dn; bit oc, ss, ia, to;
        bit hit;
        set_req(2, 45, 4);
        do_txn(4'b0100, 1'b0, av, lat, ad, dd, dn, oc, ss, bc, ia, to);
        exp_ptr = 3;
        set_req(3, 231, 10);
        req = 4'b1000;
        hit = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (v1 && a1 == 5'd11) begin hit = 1'b1; break; end
        end
        n_vec++; if (!hit) begin n_err++; $display("FAIL arst_reach_tens got=timeout exp=send_tens"); end
        rst = 1'b1;
        req = 4'b0000;
        #1;
        n_vec++; if (v1 !== 1'b0 || busy1 !== 1'b0) begin n_err++; $display("FAIL arst_immediate got=v%b b%b exp=v0 b0", v1, busy1); end
        @(negedge clk);
        rst = 1'b0;
        exp_ptr = 0;
        set_req(1, 68, 20);
        set_req(3, 99, 0);
        do_txn(4'b1010, 1'b0, av, lat, ad, dd, dn, oc, ss, bc, ia, to);
        n_vec++; if (to || av !== 4'(1 << ref_grant(4'b1010, exp_ptr))) begin n_err++; $display("FAIL arst_ptr got=%b exp=0010", av); end
        n_vec++; if (dd !== ref_text(68, 1) || ad !== ref_addrs(20)) begin n_err++; $display("FAIL arst_after got=%h/%h exp=%h/%h", dd, ad, ref_text(68, 1), ref_addrs(20)); end
        exp_ptr = 2;
    endtask

    task automatic test_random();
        for (int it = 0; it < 25; it++) begin
            logic [3:0] av, mask; int lat, bc, g; logic [14:0] ad; logic [23:0] dd, dn; bit oc, ss, ia, to, st;
            for (int i = 0; i < 4; i++) set_req(i, $urandom_range(0, 255), $urandom_range(0, 31));
            mask = 4'($urandom_range(1, 15));
            st = 1'($urandom_range(0, 1));
            g = ref_grant(mask, exp_ptr);
            do_txn(mask, st, av, lat, ad, dd, dn, oc, ss, bc, ia, to);
            exp_ptr = (g + 1) % 4;
            n_vec++; if (to || av !== 4'(1 << g)) begin n_err++; $display("FAIL rand_grant it=%0d mask=%b got=%b exp=%b", it, mask, av, 4'(1 << g)); end
            n_vec++; if (dd !== ref_text(int'(req_value[8*g +: 8]), 1)) begin n_err++; $display("FAIL rand_data it=%0d got=%h exp=%h", it, dd, ref_text(int'(req_value[8*g +: 8]), 1)); end
            n_vec++; if (dn !== ref_text(int'(req_value[8*g +: 8]), 0)) begin n_err++; $display("FAIL rand_data_nb it=%0d got=%h exp=%h", it, dn, ref_text(int'(req_value[8*g +: 8]), 0)); end
            n_vec++; if (ad !== ref_addrs(int'(req_addr[5*g +: 5]))) begin n_err++; $display("FAIL rand_addr it=%0d got=%h exp=%h", it, ad, ref_addrs(int'(req_addr[5*g +: 5]))); end
            n_vec++; if (bc != (st ? 7 : 4) || !ia || !oc || !ss) begin n_err++; $display("FAIL rand_timing it=%0d busy=%0d idle=%b exp_busy=%0d", it, bc, ia, st ? 7 : 4); end
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    initial begin
        rst       = 1'b1;
        req       = 4'b0000;
        req_value = '0;
        req_addr  = '0;
        chr_ready = 1'b1;
        test_reset();
        test_single();
        test_blanking();
        test_round_robin();
        test_backpressure();
        test_addr_wrap();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
